// File: rtl/zone_light_pkg.sv
// Shared types and helpers for the zone-brightness writer.
package zone_light_pkg;

  localparam int LIGHT_W = 16;
  localparam int INDEX_W = 9;
  localparam int LUMA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_REFRESH = 2'd2
  } zl_state_e;

  // Luma approximation used for peak tracking: brightest of the three channels.
  function automatic logic [LUMA_W-1:0] max3(input logic [LUMA_W-1:0] a,
                                             input logic [LUMA_W-1:0] b,
                                             input logic [LUMA_W-1:0] c);
    logic [LUMA_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zone_peak_bank.sv
// Per-column peak registers: an accumulate bank fed by the pixel stream and a
// shadow bank that holds a finished band while it is being written out.
module zone_peak_bank
  import zone_light_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int COL_W = $clog2(COLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_en,
  input  logic [COL_W-1:0]  upd_col,
  input  logic [LUMA_W-1:0] upd_luma,
  input  logic              clr,
  input  logic              copy,
  input  logic              rd_acc,
  input  logic [COL_W-1:0]  rd_col,
  output logic [LUMA_W-1:0] rd_peak
);

  logic [LUMA_W-1:0] acc_q [COLS];
  logic [LUMA_W-1:0] acc_d [COLS];
  logic [LUMA_W-1:0] shd_q [COLS];
  logic [LUMA_W-1:0] shd_d [COLS];

  // Next-state: copy to shadow sees the pre-clear accumulate contents.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      acc_d[c] = acc_q[c];
      shd_d[c] = shd_q[c];
      if (copy) shd_d[c] = acc_q[c];
      if (clr) begin
        acc_d[c] = '0;
      end else if (upd_en && (upd_col == COL_W'(c)) && (upd_luma > acc_q[c])) begin
        acc_d[c] = upd_luma;
      end
    end
  end

  // Bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        acc_q[c] <= '0;
        shd_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        acc_q[c] <= acc_d[c];
        shd_q[c] <= shd_d[c];
      end
    end
  end

  // Read port; rd_acc lets the first write of a band bypass the shadow copy.
  always_comb begin
    rd_peak = '0;
    for (int c = 0; c < COLS; c++) begin
      if (rd_col == COL_W'(c)) rd_peak = rd_acc ? acc_q[c] : shd_q[c];
    end
  end

endmodule

// File: rtl/zone_light_gen.sv
// Zone peak-luma writer: reduces each video frame to ZONE_COLS x ZONE_ROWS
// peaks and writes them as indexed 16-bit light values, then a refresh pulse.
// Optional macro LIGHT_FLOOR_EN clamps every emitted value to at least MIN_LIGHT.
//
// Handshake: light_valid is a one-cycle write strobe with no back-pressure;
// light/light_index are meaningful only while light_valid=1 and hold otherwise.
// light_refresh pulses for one cycle, never together with light_valid.
module zone_light_gen
  import zone_light_pkg::*;
#(
  parameter int               H_ACTIVE  = 1280,
  parameter int               V_ACTIVE  = 720,
  parameter int               ZONE_COLS = 32,
  parameter int               ZONE_ROWS = 16,
  parameter logic [LIGHT_W-1:0] MIN_LIGHT = 16'h0400
) (
  input  logic               I_clk,
  input  logic               sys_rst,
  input  logic               I_vs,
  input  logic               I_de,
  input  logic [23:0]        I_pix,
  output logic               light_valid,
  output logic [LIGHT_W-1:0] light,
  output logic [INDEX_W-1:0] light_index,
  output logic               light_refresh,
  output logic               overflow,
  output zl_state_e          dbg_state
);

  localparam int ZW    = H_ACTIVE / ZONE_COLS;
  localparam int BH    = V_ACTIVE / ZONE_ROWS;
  localparam int PX_W  = $clog2(H_ACTIVE + 1);
  localparam int LN_W  = $clog2(V_ACTIVE + 1);
  localparam int SUB_W = $clog2(ZW + 1);
  localparam int COL_W = $clog2(ZONE_COLS + 1);
  localparam int BL_W  = $clog2(BH + 1);
  localparam int ROW_W = $clog2(ZONE_ROWS + 1);

`ifdef LIGHT_FLOOR_EN
  localparam logic FLOOR_ON = 1'b1;
`else
  localparam logic FLOOR_ON = 1'b0;
`endif

  logic              vs_q, de_q;
  logic [PX_W-1:0]   px_q, px_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LN_W-1:0]   ln_q, ln_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic [ROW_W-1:0]  row_q, row_d;

  zl_state_e         state_q;
  logic [COL_W-1:0]  ecol_q;
  logic [ROW_W-1:0]  erow_q;
  logic              light_valid_q, light_refresh_q, overflow_q;
  logic [LIGHT_W-1:0] light_q;
  logic [INDEX_W-1:0] light_index_q;

  logic              vs_rise, de_fall, px_ok, ln_ok, pix_take, band_end, accept;
  logic [LUMA_W-1:0] luma, rd_peak;
  logic [COL_W-1:0]  emit_col;
  logic [ROW_W-1:0]  emit_row;
  logic [INDEX_W-1:0] idx_c;
  logic [LIGHT_W-1:0] raw_c, light_c;

  // Edge detection, range gating and band-end decision.
  always_comb begin
    vs_rise  = I_vs & ~vs_q;
    de_fall  = ~I_de & de_q;
    px_ok    = (px_q < PX_W'(H_ACTIVE));
    ln_ok    = (ln_q < LN_W'(V_ACTIVE));
    pix_take = I_de & px_ok & ln_ok & ~vs_rise;
    band_end = de_fall & ln_ok & ~vs_rise & (bl_q == BL_W'(BH - 1));
    accept   = band_end & (state_q == ST_IDLE);
    luma     = max3(I_pix[23:16], I_pix[15:8], I_pix[7:0]);
  end

  // Pixel/line position counters; zone column tracked without a divider.
  always_comb begin
    px_d  = px_q;
    sub_d = sub_q;
    col_d = col_q;
    ln_d  = ln_q;
    bl_d  = bl_q;
    row_d = row_q;
    if (vs_rise) begin
      px_d  = '0;
      sub_d = '0;
      col_d = '0;
      ln_d  = '0;
      bl_d  = '0;
      row_d = '0;
    end else begin
      if (I_de && px_ok) begin
        px_d = px_q + PX_W'(1);
        if (sub_q == SUB_W'(ZW - 1)) begin
          sub_d = '0;
          col_d = col_q + COL_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      if (de_fall) begin
        px_d  = '0;
        sub_d = '0;
        col_d = '0;
        if (ln_ok) begin
          ln_d = ln_q + LN_W'(1);
          if (bl_q == BL_W'(BH - 1)) begin
            bl_d  = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            bl_d = bl_q + BL_W'(1);
          end
        end
      end
    end
  end

  // Counter and edge-history registers.
  always_ff @(posedge I_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      px_q  <= '0;
      sub_q <= '0;
      col_q <= '0;
      ln_q  <= '0;
      bl_q  <= '0;
      row_q <= '0;
    end else begin
      vs_q  <= I_vs;
      de_q  <= I_de;
      px_q  <= px_d;
      sub_q <= sub_d;
      col_q <= col_d;
      ln_q  <= ln_d;
      bl_q  <= bl_d;
      row_q <= row_d;
    end
  end

  zone_peak_bank #(
    .COLS  (ZONE_COLS),
    .COL_W (COL_W)
  ) u_bank (
    .clk      (I_clk),
    .rst      (sys_rst),
    .upd_en   (pix_take),
    .upd_col  (col_q),
    .upd_luma (luma),
    .clr      (vs_rise | band_end),
    .copy     (accept),
    .rd_acc   (accept),
    .rd_col   (emit_col),
    .rd_peak  (rd_peak)
  );

  // Value and index of the write issued this cycle; column 0 of a new band is
  // read straight from the accumulate bank so it lands one cycle after band end.
  always_comb begin
    emit_col = accept ? '0 : ecol_q;
    emit_row = accept ? row_q : erow_q;
    idx_c    = INDEX_W'(emit_row) * INDEX_W'(ZONE_COLS) + INDEX_W'(emit_col);
    raw_c    = {rd_peak, rd_peak};
    light_c  = (FLOOR_ON && (raw_c < MIN_LIGHT)) ? MIN_LIGHT : raw_c;
  end

  // Emission FSM with registered write/refresh outputs and sticky overflow.
  always_ff @(posedge I_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q         <= ST_IDLE;
      ecol_q          <= '0;
      erow_q          <= '0;
      light_valid_q   <= 1'b0;
      light_q         <= '0;
      light_index_q   <= '0;
      light_refresh_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      light_refresh_q <= 1'b0;
      if (vs_rise) overflow_q <= 1'b0;
      else if (band_end && (state_q != ST_IDLE)) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          light_valid_q <= 1'b0;
          if (accept) begin
            state_q       <= ST_EMIT;
            erow_q        <= row_q;
            ecol_q        <= COL_W'(1);
            light_valid_q <= 1'b1;
            light_index_q <= idx_c;
            light_q       <= light_c;
          end
        end
        ST_EMIT: begin
          if (ecol_q == COL_W'(ZONE_COLS)) begin
            light_valid_q <= 1'b0;
            if (erow_q == ROW_W'(ZONE_ROWS - 1)) begin
              light_refresh_q <= 1'b1;
              state_q         <= ST_REFRESH;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            light_valid_q <= 1'b1;
            light_index_q <= idx_c;
            light_q       <= light_c;
            ecol_q        <= ecol_q + COL_W'(1);
          end
        end
        ST_REFRESH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign light_valid   = light_valid_q;
  assign light         = light_q;
  assign light_index   = light_index_q;
  assign light_refresh = light_refresh_q;
  assign overflow      = overflow_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_zone_light_gen.sv
// Scoreboard bench for zone_light_gen on a reduced 64x32 raster with the
// full 32x16 zone grid (2x2-pixel zones, 2-line bands).
module tb_zone_light_gen;
  import zone_light_pkg::*;

  localparam int H  = 64;
  localparam int V  = 32;
  localparam int ZC = 32;
  localparam int ZR = 16;
  localparam int HB = 4;

  logic               I_clk = 1'b0;
  logic               sys_rst;
  logic               I_vs, I_de;
  logic [23:0]        I_pix;
  logic               light_valid, light_refresh, overflow;
  logic [15:0]        light;
  logic [8:0]         light_index;
  zl_state_e          dbg_state;

  // Entry: {is_refresh, index[8:0], light[15:0]}
  logic [25:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  zone_light_gen #(
    .H_ACTIVE (H), .V_ACTIVE (V), .ZONE_COLS (ZC), .ZONE_ROWS (ZR), .MIN_LIGHT (16'h0400)
  ) dut (
    .I_clk (I_clk), .sys_rst (sys_rst), .I_vs (I_vs), .I_de (I_de), .I_pix (I_pix),
    .light_valid (light_valid), .light (light), .light_index (light_index),
    .light_refresh (light_refresh), .overflow (overflow), .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 I_clk = ~I_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Expected model
  function automatic logic [15:0] exp_light(input logic [7:0] p);
    logic [15:0] v;
    v = {p, p};
`ifdef LIGHT_FLOOR_EN
    if (v < 16'h0400) v = 16'h0400;
`endif
    return v;
  endfunction

  function automatic logic [7:0] exp_peak(input int mode, input int c, input int r);
    int m;
    case (mode)
      0: return 8'h30;
      1: return (c == 1 && r == 1) ? 8'hFF : 8'h00;
      3: begin
        m = 5;
        if (2 * c + 1 > m) m = 2 * c + 1;
        if (2 * r + 1 > m) m = 2 * r + 1;
        return 8'(m);
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] gen_pix(input int mode, input int p, input int l);
    case (mode)
      0: return 24'h102030;
      1: return (p == 3 && l == 2) ? 24'hFF0000 : 24'h000000;
      3: return (p >= H || l >= V) ? 24'hFFFFFF : {8'(p), 8'(l), 8'h05};
      default: return 24'h000000;
    endcase
  endfunction

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_rows(input int mode, input int r0, input int r1, input bit refresh);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < ZC; c++)
        exp_q.push_back({1'b0, 9'(r * ZC + c), exp_light(exp_peak(mode, c, r))});
    if (refresh) exp_q.push_back({1'b1, 25'h0});
  endtask

  task automatic push_row_col0(input int r, input logic [7:0] p0);
    for (int c = 0; c < ZC; c++)
      exp_q.push_back({1'b0, 9'(r * ZC + c), exp_light((c == 0) ? p0 : 8'h00)});
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(posedge I_clk);
      cnt++;
    end
    repeat (40) @(posedge I_clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic vs_pulse();
    @(negedge I_clk); I_vs = 1'b1;
    @(negedge I_clk);
    @(negedge I_clk); I_vs = 1'b0;
    repeat (2) @(negedge I_clk);
  endtask

  task automatic run_lines(input int mode, input int l0, input int n);
    int npx;
    npx = (mode == 3) ? H + 4 : H;
    for (int l = l0; l < l0 + n; l++) begin
      for (int p = 0; p < npx; p++) begin
        @(negedge I_clk); I_de = 1'b1; I_pix = gen_pix(mode, p, l);
      end
      repeat (HB) begin
        @(negedge I_clk); I_de = 1'b0; I_pix = 24'h0;
      end
    end
  endtask

  task automatic short_line(input logic [23:0] p);
    @(negedge I_clk); I_de = 1'b1; I_pix = p;
    @(negedge I_clk); I_de = 1'b0; I_pix = 24'h0;
  endtask

  // Monitor: pops one expected entry per presented write or refresh pulse.
  initial begin
    logic [25:0] e;
    forever begin
      @(posedge I_clk); #1;
      if (light_valid && light_refresh) begin
        n_cmp++; n_fail++;
        $display("FAIL valid_with_refresh: got valid=1 refresh=1, expected never both");
      end
      if (light_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got idx %0d light %h, expected no write", light_index, light);
        end else begin
          e = exp_q.pop_front();
          if (e[25] || e[24:16] !== light_index || e[15:0] !== light) begin
            n_fail++;
            $display("FAIL write: got idx %0d light %h, expected idx %0d light %h refresh %0d",
                     light_index, light, e[24:16], e[15:0], e[25]);
          end
        end
      end
      if (light_refresh) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_refresh: got refresh pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          if (!e[25]) begin
            n_fail++;
            $display("FAIL refresh_order: got refresh, expected write idx %0d light %h", e[24:16], e[15:0]);
          end
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    int cnt;
    sys_rst = 1'b1; I_vs = 1'b0; I_de = 1'b0; I_pix = 24'h0;
    repeat (3) @(negedge I_clk);
    check("rst_valid", light_valid, 0);
    check("rst_light", light, 0);
    check("rst_index", light_index, 0);
    check("rst_refresh", light_refresh, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, ST_IDLE);
    sys_rst = 1'b0;
    repeat (2) @(negedge I_clk);

    // Constant frame
    vs_pulse();
    push_rows(0, 0, ZR - 1, 1'b1);
    run_lines(0, 0, V);
    drain("const_frame_drain");

    // Single bright pixel
    vs_pulse();
    push_rows(1, 0, ZR - 1, 1'b1);
    run_lines(1, 0, V);
    drain("single_pixel_drain");

    // Gradient with overrun pixels and overrun lines
    vs_pulse();
    push_rows(3, 0, ZR - 1, 1'b1);
    run_lines(3, 0, V + 2);
    drain("gradient_overrun_drain");

    // Frame aborted after 5 lines, then a full frame
    vs_pulse();
    push_rows(0, 0, 1, 1'b0);
    run_lines(0, 0, 5);
    vs_pulse();
    push_rows(0, 0, ZR - 1, 1'b1);
    run_lines(0, 0, V);
    drain("abort_then_full_drain");

    // Band end during emission: row 1 is dropped, row 2 still emitted
    vs_pulse();
    check("ovf_clear_at_start", overflow, 0);
    push_row_col0(0, 8'h50);
    push_row_col0(2, 8'h11);
    short_line(24'h000050);
    short_line(24'h000050);
    short_line(24'h700000);
    short_line(24'h700000);
    repeat (40) @(negedge I_clk);
    short_line(24'h000011);
    short_line(24'h000011);
    drain("overflow_drain");
    check("ovf_set", overflow, 1);
    vs_pulse();
    check("ovf_cleared_by_vs", overflow, 0);

    // Reset in the middle of an emission
    push_rows(0, 0, 0, 1'b0);
    run_lines(0, 0, 2);
    cnt = 0;
    while (exp_q.size() > 16 && cnt < 200) begin
      @(posedge I_clk);
      cnt++;
    end
    @(posedge I_clk); #2;
    check("mid_emit_active", light_valid, 1);
    #1 sys_rst = 1'b1;
    #1;
    check("mid_rst_valid", light_valid, 0);
    check("mid_rst_light", light, 0);
    check("mid_rst_index", light_index, 0);
    check("mid_rst_refresh", light_refresh, 0);
    exp_q.delete();
    repeat (2) @(negedge I_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge I_clk);
    vs_pulse();
    push_rows(1, 0, ZR - 1, 1'b1);
    run_lines(1, 0, V);
    drain("post_reset_frame_drain");

    // Black frame (floor value when LIGHT_FLOOR_EN is defined)
    vs_pulse();
    push_rows(2, 0, ZR - 1, 1'b1);
    run_lines(2, 0, V);
    drain("black_frame_drain");
    check("final_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/zone_light_gen.md
Name: zone_light_gen

Overview:
- Writer side of the zone-brightness interface between the LVDS video path and the MiniLED driver.
- Takes a decoded active-video pixel stream and reduces each frame to ZONE_COLS x ZONE_ROWS zone peak-luma values.
- Emits those values as indexed 16-bit `light` writes, followed by a one-cycle `light_refresh` pulse per completed frame.
- Sits between the LVDS video receiver/decoder and `MiniLED_driver`.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- ZONE_COLS, 32, zones horizontally; H_ACTIVE must be divisible by it
- ZONE_ROWS, 16, zones vertically; V_ACTIVE must be divisible by it; ZONE_COLS*ZONE_ROWS <= 512
- MIN_LIGHT, 16'h0400, floor value; used only with LIGHT_FLOOR_EN

Ports:
- I_clk  in  1  pixel/system clock
- sys_rst  in  1  asynchronous reset, active-high
- I_vs  in  1  vertical sync, active-high; rising edge marks start of frame
- I_de  in  1  data enable, active-high during active pixels
- I_pix  in  24  RGB888 as {R,G,B}, valid when I_de=1
- light_valid  out  1  write strobe for light/light_index
- light  out  16  zone brightness value
- light_index  out  9  zone index = row*ZONE_COLS + col
- light_refresh  out  1  one-cycle pulse after the last zone of a frame is written
- overflow  out  1  sticky error flag; cleared by reset or by an I_vs rising edge

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; counters 0; both peak banks 0; FSM in IDLE.
- Pixel luma: luma = max(R,G,B), 8 bits.
- Counters:
  - px increments on each I_de=1 cycle.
  - At each I_de falling edge, px clears and ln increments.
  - Zone column = px / (H_ACTIVE/ZONE_COLS), implemented as a sub-counter plus col counter, with no divider.
- Overrun handling:
  - Pixels with px >= H_ACTIVE are ignored.
  - Lines with ln >= V_ACTIVE are ignored.
  - No wrap occurs and no error is raised.
- I_vs rising edge:
  - Clears px, ln, the accumulate bank and overflow.
  - Abandons any partial band; no refresh is produced for the abandoned frame.
  - An emission already in progress completes normally.
- Accumulate bank: ZONE_COLS x 8-bit peaks, acc[col] <= max(acc[col], luma).
- Band end: when the I_de falling edge completes line ln with (ln+1) % (V_ACTIVE/ZONE_ROWS) == 0, then in the same cycle:
  - the accumulate bank is copied to the shadow bank,
  - the accumulate bank is cleared,
  - the band row number is latched.
- FSM states and transitions:
  - IDLE -> EMIT on a band end.
  - EMIT: one write per cycle for col = 0..ZONE_COLS-1.
    - light_valid=1, light_index=row*ZONE_COLS+col, light={peak,peak} (×257, so 8'hFF→16'hFFFF and 0→0).
  - EMIT -> REFRESH after the last column, if the row is ZONE_ROWS-1; otherwise EMIT -> IDLE.
  - REFRESH: light_refresh=1 for exactly one cycle with light_valid=0, then -> IDLE.
- Latency: the first write appears the cycle after the band-ending I_de falling edge. The refresh pulse follows the write of index 511 (at default parameters) by one cycle.
- Band end while in EMIT or REFRESH:
  - overflow is set.
  - The new band is dropped and the shadow bank is not overwritten.
  - The accumulate bank is still cleared.
- light and light_index hold their last values when light_valid=0.
- Reset asserted mid-emission: outputs go to 0 immediately (asynchronously) and no partial refresh occurs.

Optional Feature:
- Macro: LIGHT_FLOOR_EN.
- Defined: each emitted value is max({peak,peak}, MIN_LIGHT), so no zone goes fully dark.
- Undefined: the value is emitted unmodified and MIN_LIGHT is unused.

Decomposition:
- Shared package `zone_light_pkg`:
  - FSM state enum (IDLE, EMIT, REFRESH),
  - LIGHT_W=16, INDEX_W=9, LUMA_W=8,
  - luma function max3.
- One natural sub-module: `zone_peak_bank`, holding the accumulate/shadow register pair, the per-column max update, the copy/clear on band end, and the read port by column.

Test Plan:
- Reset then a full frame of constant I_pix=24'h102030 -> 512 writes, all light=16'h3030, indices 0..511 in order, then one light_refresh pulse.
- Single pixel 24'hFF0000 at (px=45, ln=50), rest black -> index 1*32+1=33 gives 16'hFFFF; all other indices give 0.
- I_vs asserted after 100 lines, then a full frame -> no refresh for the aborted frame; the next frame yields exactly 512 writes and one refresh.
- Band end forced during EMIT (band height shortened via parameter, e.g. V_ACTIVE=32/ZONE_ROWS=16 with 2-line bands and 1-cycle hblank) -> overflow=1, dropped band's indices are absent, and overflow clears on the next I_vs.
- sys_rst pulsed mid-EMIT -> light_valid, light, light_index and light_refresh read 0 in the same cycle; the next frame is emitted correctly.
- With LIGHT_FLOOR_EN, a black frame -> all 512 writes have light=16'h0400; without it, all are 0.
